// File: rtl/seq_pkg.sv
// seq_pkg: state encoding, default widths and period clamp shared by sample_sequencer.
package seq_pkg;
    localparam int SEQ_PERIOD_W = 8;
    localparam int SEQ_CNT_W = 16;
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} seq_state_t;
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return p == 32'd0 ? 32'd1 : p;
    endfunction
endpackage

// File: rtl/sample_sequencer_period_counter.sv
// period_counter: modulo-period phase counter with clear, advance enable and wrap flag.
module period_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         i_reset,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] period,
    output logic [W-1:0] count,
    output logic         wrap
);
    assign wrap = count == period - W'(1);
    always_ff @(posedge clock)
        if (i_reset || clear) count <= '0;
        else if (advance) count <= wrap ? '0 : count + W'(1);
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: run/stop controller issuing per-period tick and phase-aligned sample enable.
// Define SEQ_HOLD_EN to add i_hold, which freezes the run without aborting it.
module sample_sequencer
    import seq_pkg::*;
#(
    parameter int PERIOD_W = SEQ_PERIOD_W,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
`ifdef SEQ_HOLD_EN
    input  logic                i_hold,
`endif
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [PERIOD_W-1:0] i_phase,
    input  logic [CNT_W-1:0]    i_num_ticks,
    output logic                o_tick,
    output logic                o_sample_en,
    output logic                o_busy,
    output logic                o_done,
    output logic [CNT_W-1:0]    o_tick_count
);
    seq_state_t state, state_n;
    logic [PERIOD_W-1:0] period_l, phase_l, peff_n, phase_cnt;
    logic [CNT_W-1:0] num_l, tick_count;
    logic hold, run, wrap, last;
`ifdef SEQ_HOLD_EN
    assign hold = i_hold;
`else
    assign hold = 1'b0;
`endif
    assign run = state == RUN && !hold;
    assign peff_n = PERIOD_W'(clamp_period(32'(i_period)));
    period_counter #(.W(PERIOD_W)) u_period_counter (
        .clock(clock),
        .i_reset(i_reset),
        .clear(state != RUN),
        .advance(run),
        .period(period_l),
        .count(phase_cnt),
        .wrap(wrap)
    );
    assign o_tick = run && wrap;
    assign o_sample_en = run && phase_cnt == phase_l;
    assign o_busy = state == ARM || state == RUN;
    assign o_done = state == DONE;
    assign o_tick_count = tick_count;
    // the final budgeted tick takes priority over a simultaneous stop
    assign last = o_tick && num_l != '0 && tick_count == num_l - CNT_W'(1);
    always_comb
        state_n = state == IDLE ? (i_start && !i_stop ? ARM : IDLE) :
                  state == ARM  ? (i_stop ? IDLE : RUN) :
                  state == RUN  ? (last ? DONE : i_stop ? IDLE : RUN) : IDLE;
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state <= IDLE;
            period_l <= '0;
            phase_l <= '0;
            num_l <= '0;
            tick_count <= '0;
        end else begin
            state <= state_n;
            if (state == ARM) begin
                period_l <= peff_n;
                phase_l <= i_phase > peff_n - PERIOD_W'(1) ? peff_n - PERIOD_W'(1) : i_phase;
                num_l <= i_num_ticks;
                tick_count <= '0;
            end else if (o_tick && tick_count != '1) begin
                tick_count <= tick_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: table vectors, directed corner sequences and random run against a cycle model.
module tb_sample_sequencer;
    logic clock = 1'b0;
    logic i_reset = 1'b1, i_start = 1'b0, i_stop = 1'b0, hold = 1'b0;
    logic [7:0] i_period = 8'd0, i_phase = 8'd0;
    logic [15:0] i_num_ticks = 16'd0;
    logic o_tick, o_sample_en, o_busy, o_done;
    logic [15:0] o_tick_count;
    logic s_tick, s_se, s_busy, s_done;
    logic [15:0] s_cnt;
    int n_cmp = 0, n_bad = 0;
    int m_st = 0, m_adv = 0, m_peff = 1, m_ph = 0, m_n = 0, m_ticks = 0;

    always #5 clock = ~clock;

    sample_sequencer dut (
        .clock(clock),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_stop(i_stop),
`ifdef SEQ_HOLD_EN
        .i_hold(hold),
`endif
        .i_period(i_period),
        .i_phase(i_phase),
        .i_num_ticks(i_num_ticks),
        .o_tick(o_tick),
        .o_sample_en(o_sample_en),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_tick_count(o_tick_count)
    );

    typedef struct {
        logic start, stop, tick, se, busy, done;
        logic [15:0] cnt;
    } vec_t;
    vec_t tv[16];

    function automatic vec_t mk(logic st, logic sp, logic t, logic s, logic b, logic d, int c);
        vec_t v;
        v.start = st; v.stop = sp; v.tick = t; v.se = s; v.busy = b; v.done = d; v.cnt = 16'(c);
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: sample at negedge, optionally compare with the model, then advance the model
    task automatic cyc(input bit use_model);
        bit run, et, es;
        @(negedge clock);
        s_tick = o_tick; s_se = o_sample_en; s_busy = o_busy; s_done = o_done; s_cnt = o_tick_count;
        run = m_st == 2 && !hold;
        et = run && (m_adv % m_peff) == m_peff - 1;
        es = run && (m_adv % m_peff) == m_ph;
        if (use_model) begin
            chk1("tick", s_tick, et);
            chk1("sample_en", s_se, es);
            chk1("busy", s_busy, m_st == 1 || m_st == 2);
            chk1("done", s_done, m_st == 3);
            chk("tick_count", 32'(s_cnt), m_ticks);
        end
        @(posedge clock);
        if (i_reset) begin
            m_st = 0; m_adv = 0; m_ticks = 0;
        end else begin
            case (m_st)
                0: if (i_start && !i_stop) m_st = 1;
                1: begin
                    m_peff = i_period == 0 ? 1 : int'(i_period);
                    m_ph = int'(i_phase) < m_peff ? int'(i_phase) : m_peff - 1;
                    m_n = int'(i_num_ticks);
                    m_adv = 0;
                    m_ticks = 0;
                    m_st = i_stop ? 0 : 2;
                end
                2: begin
                    if (et && m_ticks < 65535) m_ticks++;
                    if (!hold) m_adv++;
                    m_st = (et && m_n != 0 && m_ticks == m_n) ? 3 : i_stop ? 0 : 2;
                end
                default: m_st = 0;
            endcase
        end
        #1;
    endtask

    initial begin
        int k;
        tv[0]  = mk(1, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 0, 0, 0, 1, 0, 0);
        tv[2]  = mk(0, 0, 0, 0, 1, 0, 0);
        tv[3]  = mk(0, 0, 0, 1, 1, 0, 0);
        tv[4]  = mk(0, 0, 0, 0, 1, 0, 0);
        tv[5]  = mk(0, 0, 1, 0, 1, 0, 0);
        tv[6]  = mk(0, 0, 0, 0, 1, 0, 1);
        tv[7]  = mk(0, 0, 0, 1, 1, 0, 1);
        tv[8]  = mk(0, 0, 0, 0, 1, 0, 1);
        tv[9]  = mk(0, 0, 1, 0, 1, 0, 1);
        tv[10] = mk(0, 0, 0, 0, 1, 0, 2);
        tv[11] = mk(0, 0, 0, 1, 1, 0, 2);
        tv[12] = mk(0, 0, 0, 0, 1, 0, 2);
        tv[13] = mk(1, 0, 1, 0, 1, 0, 2);
        tv[14] = mk(0, 0, 0, 0, 0, 1, 3);
        tv[15] = mk(0, 0, 0, 0, 0, 0, 3);

        cyc(0);
        cyc(0);
        i_reset = 1'b0;
        chk1("reset_tick", s_tick, 1'b0);
        chk1("reset_se", s_se, 1'b0);
        chk1("reset_busy", s_busy, 1'b0);
        chk1("reset_done", s_done, 1'b0);
        chk("reset_count", 32'(s_cnt), 0);

        // P=4 phase=1 N=3, start at table cycle 0
        i_period = 8'd4; i_phase = 8'd1; i_num_ticks = 16'd3;
        for (int i = 0; i < 16; i++) begin
            i_start = tv[i].start; i_stop = tv[i].stop;
            cyc(1);
            chk1("tv_tick", s_tick, tv[i].tick);
            chk1("tv_se", s_se, tv[i].se);
            chk1("tv_busy", s_busy, tv[i].busy);
            chk1("tv_done", s_done, tv[i].done);
            chk("tv_count", 32'(s_cnt), 32'(tv[i].cnt));
        end
        i_start = 1'b0;

        // period 0 behaves as 1, phase clamps to 0
        i_period = 8'd0; i_phase = 8'd5; i_num_ticks = 16'd2; i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        cyc(1);
        cyc(1);
        chk1("p0_tick_c2", s_tick, 1'b1);
        chk1("p0_se_c2", s_se, 1'b1);
        cyc(1);
        chk1("p0_tick_c3", s_tick, 1'b1);
        chk1("p0_se_c3", s_se, 1'b1);
        cyc(1);
        chk1("p0_done_c4", s_done, 1'b1);
        cyc(1);

        // free-running, stopped after 10 ticks
        i_period = 8'd3; i_phase = 8'd0; i_num_ticks = 16'd0; i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        k = 0;
        for (int j = 0; j < 200 && k < 10; j++) begin
            cyc(1);
            if (s_tick) k++;
        end
        chk("ten_ticks_seen", k, 10);
        i_stop = 1'b1;
        cyc(1);
        i_stop = 1'b0;
        cyc(1);
        chk1("stop_busy", s_busy, 1'b0);
        chk1("stop_done", s_done, 1'b0);
        chk("stop_count_held", 32'(s_cnt), 10);
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        cyc(1);
        cyc(1);
        chk("restart_count_cleared", 32'(s_cnt), 0);
        i_stop = 1'b1;
        cyc(1);
        i_stop = 1'b0;
        cyc(1);

        // stop coincident with final tick: DONE wins
        i_period = 8'd4; i_num_ticks = 16'd2; i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        repeat (8) cyc(1);
        i_stop = 1'b1;
        cyc(1);
        chk1("stop_at_last_tick", s_tick, 1'b1);
        i_stop = 1'b0;
        cyc(1);
        chk1("stop_last_done", s_done, 1'b1);
        chk("stop_last_count", 32'(s_cnt), 2);
        cyc(1);

        // reset in the third RUN cycle
        i_period = 8'd5; i_num_ticks = 16'd0; i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        repeat (3) cyc(1);
        i_reset = 1'b1;
        cyc(1);
        i_reset = 1'b0;
        cyc(1);
        chk1("midrun_reset_busy", s_busy, 1'b0);
        chk1("midrun_reset_tick", s_tick, 1'b0);
        chk1("midrun_reset_se", s_se, 1'b0);
        chk1("midrun_reset_done", s_done, 1'b0);
        chk("midrun_reset_count", 32'(s_cnt), 0);
        i_start = 1'b1; i_stop = 1'b1;
        cyc(1);
        i_start = 1'b0; i_stop = 1'b0;
        cyc(1);
        chk1("start_with_stop_idle", s_busy, 1'b0);

`ifdef SEQ_HOLD_EN
        // hold three cycles mid-period shifts ticks by 3
        i_period = 8'd4; i_phase = 8'd1; i_num_ticks = 16'd2; i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        cyc(1);
        cyc(1);
        hold = 1'b1;
        repeat (3) begin
            cyc(1);
            chk1("hold_no_tick", s_tick, 1'b0);
            chk1("hold_no_se", s_se, 1'b0);
        end
        hold = 1'b0;
        cyc(1);
        chk1("hold_se_shifted", s_se, 1'b1);
        cyc(1);
        cyc(1);
        chk1("hold_tick_shifted", s_tick, 1'b1);
        repeat (4) cyc(1);
        chk1("hold_tick2_shifted", s_tick, 1'b1);
        cyc(1);
        chk1("hold_done", s_done, 1'b1);
        cyc(1);
`endif

        for (int i = 0; i < 3000; i++) begin
            i_reset = $urandom_range(0, 99) == 0;
            i_start = $urandom_range(0, 2) == 0;
            i_stop = $urandom_range(0, 24) == 0;
            i_period = 8'($urandom_range(0, 6));
            i_phase = 8'($urandom_range(0, 7));
            i_num_ticks = 16'($urandom_range(0, 4));
`ifdef SEQ_HOLD_EN
            hold = $urandom_range(0, 4) == 0;
`endif
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
Run/stop controller for the periodic-strobe datapath. It latches a period, a sample phase and a tick budget, then drives a modulo phase counter. It emits a per-period tick and a phase-aligned sample enable to downstream stages (PRBS source, filter, downsampler, BER counter). It reports completion after a programmed number of ticks, or runs continuously.

Parameters:
PERIOD_W, 8, width of i_period, i_phase and the internal phase counter
CNT_W, 16, width of i_num_ticks and o_tick_count

Ports:
clock  input  1  system clock, all logic on posedge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  start request, sampled in IDLE only
i_stop  input  1  abort request, honoured in ARM/RUN
i_period  input  PERIOD_W  period P in cycles; 0 treated as 1
i_phase  input  PERIOD_W  cycle offset of o_sample_en within the period
i_num_ticks  input  CNT_W  tick budget N; 0 = run until stopped
o_tick  output  1  one-cycle pulse at the last cycle of each period
o_sample_en  output  1  one-cycle pulse at the phase cycle of each period
o_busy  output  1  high in ARM and RUN
o_done  output  1  one-cycle pulse when the budget is exhausted
o_tick_count  output  CNT_W  ticks issued since the last start

Behaviour:
- Reset (i_reset, synchronous, active-high; clock clock): state=IDLE, phase_cnt=0, tick_count=0, latched config=0. All outputs 0. Reset wins over every other input, including mid-RUN.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE: if i_start=1 and i_stop=0, go to ARM. i_start and i_stop together keeps IDLE.
- ARM (1 cycle): latch Peff = (i_period==0 ? 1 : i_period). Latch phase_l = min(i_phase, Peff-1) and N. Clear phase_cnt and tick_count. Go to RUN, or to IDLE if i_stop=1.
- RUN: phase_cnt counts 0..Peff-1 and wraps to 0. First RUN cycle has phase_cnt=0.
- o_tick = RUN && phase_cnt==Peff-1. o_sample_en = RUN && phase_cnt==phase_l. Both are decoded from registered state only.
- tick_count increments on every o_tick cycle and saturates at all-ones.
- If N!=0 and a tick occurs with tick_count==N-1, go to DONE next cycle.
- i_stop=1 in RUN: go to IDLE next cycle. No o_done pulse. tick_count holds its value.
- If stop and the final tick occur in the same cycle, DONE wins.
- i_start is ignored outside IDLE. Config inputs are ignored outside ARM.
- DONE (1 cycle): o_done=1, o_busy=0, then go to IDLE. o_tick_count holds until the next ARM.
- Latency: i_start at cycle t gives first RUN at t+2 and first o_tick at t+1+Peff.
- Peff=1: o_tick and o_sample_en are high every RUN cycle.

Optional Feature:
SEQ_HOLD_EN.
- Defined: adds input i_hold (1 bit). While i_hold=1 in RUN, phase_cnt, tick_count and the state freeze, and o_tick/o_sample_en are forced 0. i_stop still aborts. i_hold is ignored in the other states.
- Undefined: port absent and the counter always advances in RUN.

Decomposition:
- Package seq_pkg holds:
  - the state enum (IDLE, ARM, RUN, DONE);
  - default PERIOD_W and CNT_W localparams;
  - the Peff clamp function.
- Sub-module period_counter: modulo-Peff counter with clear, advance-enable (hold) and wrap flag. The FSM and tick/budget logic stay in sample_sequencer.

Test Plan:
- P=4, phase=1, N=3; start at cycle 0:
  - ARM at 1, RUN at 2.
  - o_sample_en at 3, 7, 11; o_tick at 5, 9, 13.
  - o_done at 14, IDLE at 15, o_tick_count=3.
- P=0, phase=5, N=2: Peff=1 and phase clamps to 0. Pulses at cycles 2 and 3, o_done at 4.
- P=3, N=0: after 10 ticks assert i_stop. Next cycle IDLE, o_done never pulses, o_tick_count=10. A new start clears the count to 0 in ARM.
- P=4, N=2: assert i_stop in the same cycle as the 2nd tick. DONE is entered and o_done pulses.
- P=5, N=0: assert i_reset in the 3rd RUN cycle. Next cycle every output is 0 and state is IDLE. i_start together with i_stop in IDLE stays in IDLE.
- SEQ_HOLD_EN, P=4, N=2: i_hold high for 3 cycles mid-period. Tick times shift by +3 and no pulses occur while held.
